alu_iter: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Keeps the forward/add/and/or operations, widens the datapath to WIDTH bits, and adds an iterative multiplier plus iterative shifts/rotate.
- Sits between the register file and the writeback mux and is controlled by the CPU control unit through a START/BUSY/DONE handshake.
- Outputs and the ZERO flag used for branching are registered.

---
 rtl/alu_iter.sv | 179 +++++++++++++++++
 tb/tb_alu_iter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// ---------------------------------------------------------------------------
// alu_iter -- multi-cycle datapath ALU
//
// Handles forward/add/and/or in one pass. Multiply runs as shift-add, one
// multiplier bit per cycle. Logical-left, arithmetic-right and rotate-right
// run as one bit position per cycle. The control unit drives it through a
// START / BUSY / DONE handshake. RESULT and ZERO are registered and change
// only on a DONE pulse.
//
// Ports
//   CLK     in   rising-edge clock
//   RESET   in   synchronous active-low reset
//   START   in   request; accepted only in IDLE and not in the DONE cycle
//   SELECT  in   [2:0] opcode, captured on accept
//   DATA1   in   [WIDTH-1:0] operand A, captured on accept
//   DATA2   in   [WIDTH-1:0] operand B / shift amount, captured on accept
//   BUSY    out  high from the cycle after accept until DONE
//   DONE    out  one-cycle pulse; RESULT/ZERO valid from this cycle
//   RESULT  out  [WIDTH-1:0] registered result
//   ZERO    out  registered, 1 iff RESULT == 0
// ---------------------------------------------------------------------------
module alu_iter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO
);

    // Step-counter width is derived from WIDTH so that it can hold WIDTH.
    localparam int              CNTW     = $clog2(WIDTH) + 1;
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(WIDTH);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]       state;
    logic [2:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic [CNTW-1:0]  cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    logic             amt_big;
    logic [CNTW-1:0]  amt_low;
    logic [CNTW-1:0]  load_n;
    logic [WIDTH-1:0] opa_step;
    logic [WIDTH-1:0] opb_step;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] fin_result;

    // Step count for the incoming request. Any set bit at or above
    // log2(WIDTH) means the amount is >= WIDTH and gets clamped for
    // SLL/SRA. ROR keeps only the low bits, which is B mod WIDTH.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path through the case leaves it unassigned, which would infer a latch.
        load_n  = '0;
        amt_big = |DATA2[WIDTH-1:CNTW-1];
        amt_low = {1'b0, DATA2[CNTW-2:0]};
        case (SELECT)
            OP_MUL:         load_n = CNT_FULL;
            OP_SLL, OP_SRA: load_n = amt_big ? CNT_FULL : amt_low;
            OP_ROR:         load_n = amt_low;
            default:        load_n = '0;
        endcase
    end

    // One iteration of the selected multi-cycle operation.
    always_comb begin
        opa_step = opa;
        opb_step = opb;
        acc_step = acc;
        case (op)
            OP_MUL: begin
                // Shift-add: add the shifted multiplicand when the current
                // multiplier LSB is set, then advance both operands.
                if (opb[0]) acc_step = acc + opa;
                opa_step = {opa[WIDTH-2:0], 1'b0};
                opb_step = {1'b0, opb[WIDTH-1:1]};
            end
            OP_SLL:  opa_step = {opa[WIDTH-2:0], 1'b0};
            OP_SRA:  opa_step = {opa[WIDTH-1], opa[WIDTH-1:1]};
            OP_ROR:  opa_step = {opa[0], opa[WIDTH-1:1]};
            default: opa_step = opa;
        endcase
    end

    // Final value written on the FIN edge.
    always_comb begin
        fin_result = opb;
        case (op)
            OP_FWD:  fin_result = opb;
            OP_ADD:  fin_result = opa + opb;
            OP_AND:  fin_result = opa & opb;
            OP_OR:   fin_result = opa | opb;
            OP_MUL:  fin_result = acc;
            default: fin_result = opa;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        if (!RESET) begin
            // NOTE: the operand and step registers are reset along with the
            // control state. An aborted operation then leaves nothing behind.
            state    <= S_IDLE;
            op       <= OP_FWD;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A START that arrives while DONE is still high is dropped.
                    if (START && !done_q) begin
                        op     <= SELECT;
                        opa    <= DATA1;
                        opb    <= DATA2;
                        acc    <= '0;
                        cnt    <= load_n;
                        busy_q <= 1'b1;
                        state  <= (load_n == '0) ? S_FIN : S_RUN;
                    end
                end
                S_RUN: begin
                    opa <= opa_step;
                    opb <= opb_step;
                    acc <= acc_step;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) state <= S_FIN;
                end
                S_FIN: begin
                    result_q <= fin_result;
                    zero_q   <= (fin_result == '0);
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;
    assign ZERO   = zero_q;

endmodule

// File: tb/tb_alu_iter.sv
// ---------------------------------------------------------------------------
// tb_alu_iter -- self-checking bench for alu_iter (WIDTH = 8)
//
// The driver pushes the expected result, the completion cycle and the
// number of BUSY cycles for each request. A negedge monitor pops one entry
// per DONE pulse and compares it. A DONE pulse with no pending entry is
// reported as an error.
// ---------------------------------------------------------------------------
module tb_alu_iter;

    localparam int WIDTH = 8;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [2:0]       sel;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;

    typedef struct {
        logic [WIDTH-1:0] result;
        int               done_cyc;
        int               busy_cycles;
        string            tag;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   busy_run  = 0;
    int   done_seen = 0;

    alu_iter #(.WIDTH(WIDTH)) dut (
        .CLK    (clk),
        .RESET  (rst_n),
        .START  (start),
        .SELECT (sel),
        .DATA1  (data1),
        .DATA2  (data2),
        .BUSY   (busy),
        .DONE   (done),
        .RESULT (result),
        .ZERO   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else if (done === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_result"}, 32'(result), 32'(e.result));
                check({e.tag, "_zero"}, 32'(zero), 32'(e.result == '0));
                check({e.tag, "_latency"}, 32'(cyc), 32'(e.done_cyc));
                check({e.tag, "_busy"}, 32'(busy_run), 32'(e.busy_cycles));
            end
            busy_run = 0;
        end else if (busy === 1'b1) begin
            busy_run++;
        end
    end

    // Request is driven at a negedge and accepted on the next posedge (cyc+1).
    // DONE is seen in the cycle after edge accept+lat-1, and BUSY covers lat-1 cycles.
    task automatic push_exp(input logic [WIDTH-1:0] exp, input int lat, input string tag);
        exp_t e;
        e.result      = exp;
        e.done_cyc    = cyc + 1 + lat - 1;
        e.busy_cycles = lat - 1;
        e.tag         = tag;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check({tag, "_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic do_op(input logic [2:0] s, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp,
                         input int lat, input string tag);
        @(negedge clk);
        sel   = s;
        data1 = a;
        data2 = b;
        start = 1'b1;
        push_exp(exp, lat, tag);
        @(negedge clk);
        start = 1'b0;
        // Scramble the inputs; the latched copies must be used.
        data1 = ~a;
        data2 = ~b;
        sel   = ~s;
        wait_drain(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sel   = OP_FWD;
        data1 = '0;
        data2 = '0;

        // Reset, then idle with START low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_result", 32'(result), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_result", 32'(result), 32'd0);
            check("idle_zero", 32'(zero), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end

        // Single-pass operations.
        do_op(OP_ADD, 8'hF0, 8'h10, 8'h00, 2, "add_wrap");
        do_op(OP_OR,  8'h0F, 8'h30, 8'h3F, 2, "or");
        do_op(OP_AND, 8'hF3, 8'h3C, 8'h30, 2, "and");
        do_op(OP_FWD, 8'h12, 8'hA5, 8'hA5, 2, "fwd");
        do_op(OP_ADD, 8'h05, 8'hFF, 8'h04, 2, "sub_twos");

        // Multiply.
        do_op(OP_MUL, 8'd13, 8'd11, 8'h8F, WIDTH + 2, "mul_13x11");
        do_op(OP_MUL, 8'hFF, 8'hFF, 8'h01, WIDTH + 2, "mul_ffxff");
        do_op(OP_MUL, 8'h00, 8'h77, 8'h00, WIDTH + 2, "mul_zero");

        // Shifts and rotate, including the clamp and modulo boundaries.
        do_op(OP_SRA, 8'h90, 8'd3,   8'hF2, 5,  "sra_3");
        do_op(OP_SRA, 8'h90, 8'd200, 8'hFF, 10, "sra_clamp");
        do_op(OP_SRA, 8'h70, 8'd8,   8'h00, 10, "sra_pos_clamp");
        do_op(OP_SLL, 8'h81, 8'd0,   8'h81, 2,  "sll_0");
        do_op(OP_SLL, 8'h81, 8'd3,   8'h08, 5,  "sll_3");
        do_op(OP_SLL, 8'hFF, 8'd9,   8'h00, 10, "sll_clamp");
        do_op(OP_ROR, 8'h01, 8'd9,   8'h80, 3,  "ror_9");
        do_op(OP_ROR, 8'h01, 8'd11,  8'h20, 5,  "ror_11");
        do_op(OP_ROR, 8'h5A, 8'd8,   8'h5A, 2,  "ror_8");

        // A START during RUN and a START in the DONE cycle are both ignored.
        @(negedge clk);
        sel   = OP_MUL;
        data1 = 8'd5;
        data2 = 8'd7;
        start = 1'b1;
        push_exp(8'd35, WIDTH + 2, "mul_hs");
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        sel   = OP_ADD;
        data1 = 8'd1;
        data2 = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && done !== 1'b1; i++) begin
            @(negedge clk);
            #1;
        end
        check("hs_done_seen", 32'(done), 32'd1);
        sel   = OP_ADD;
        data1 = 8'd2;
        data2 = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("hs_done_start_busy", 32'(busy), 32'd0);
        check("hs_result_held", 32'(result), 32'd35);
        check("hs_pending", 32'(sb.size()), 32'd0);

        // Reset in the fourth RUN cycle of a multiply aborts it.
        @(negedge clk);
        sel   = OP_MUL;
        data1 = 8'd13;
        data2 = 8'd11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_result", 32'(result), 32'd0);
        check("abort_zero", 32'(zero), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        done_seen = 0;
        repeat (15) @(negedge clk);
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_result_hold", 32'(result), 32'd0);

        do_op(OP_ADD, 8'd3, 8'd4, 8'd7, 2, "add_after_abort");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
